axi_mem_arbiter: RTL

Shares the single AXI3/AXI4-lite-style master port between N memory requesters: I-cache refill, D-cache refill/writeback, and the uncached confreg bridge. Only one transaction is outstanding at a time. Round-robin arbitration selects the winner. The block drives the AR/R or AW/W/B handshakes and routes data and completions back to the granted requester. It sits between the cache/uncached front ends and the top-level AXI interface.

---
 rtl/axi_mem_arbiter_pkg.sv | 28 ++
 rtl/axi_mem_arbiter_rr_picker.sv | 33 +++
 rtl/axi_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_arbiter_pkg.sv
// Shared definitions for the AXI memory arbiter: FSM states, ID width,
// AXI size/burst encodings and the fixed requester slots.
package axi_mem_arbiter_pkg;

    localparam int ID_W = 4;

    localparam int REQ_ICACHE   = 0;
    localparam int REQ_UNCACHED = 1;
    localparam int REQ_DCACHE   = 2;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

endpackage

// File: rtl/axi_mem_arbiter_rr_picker.sv
// Round-robin priority encoder: first requester at or after ptr, with
// wrap-around, wins. Purely combinational.
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the farthest slot back to ptr so the nearest match overwrites.
    always_comb begin
        int j;
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                winner    = '0;
                winner[j] = 1'b1;
                idx       = IDX_W'(j);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Single-outstanding AXI master port shared by N requesters under round-robin
// arbitration; routes read beats, write-beat advances and completions back.
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_rd,
    input  logic [N-1:0]       req_wr,
    input  logic [N*32-1:0]    req_addr,
    input  logic [N*LEN_W-1:0] req_len,
    input  logic [N*3-1:0]     req_size,
    input  logic [N*4-1:0]     req_wstrb,
    input  logic [N*32-1:0]    req_wdata,
    output logic [N-1:0]       grant,
    output logic [31:0]        rsp_rdata,
    output logic [N-1:0]       rsp_rvalid,
    output logic               rsp_rlast,
    output logic [N-1:0]       rsp_wnext,
    output logic [N-1:0]       rsp_done,
    output logic [ID_W-1:0]    arid,
    output logic [31:0]        araddr,
    output logic [LEN_W-1:0]   arlen,
    output logic [2:0]         arsize,
    output logic               arvalid,
    input  logic               arready,
    input  logic [ID_W-1:0]    rid,
    input  logic [31:0]        rdata,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [ID_W-1:0]    awid,
    output logic [31:0]        awaddr,
    output logic [LEN_W-1:0]   awlen,
    output logic [2:0]         awsize,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [ID_W-1:0]    bid,
    input  logic               bvalid,
    output logic               bready,
    output logic [2:0]         dbg_state
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Handshakes: a beat moves on a channel when valid and ready are both high
    // at a rising clk; valid and payload hold until then.
    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [31:0]      lat_addr;
    logic [LEN_W-1:0] lat_len;
    logic [2:0]       lat_size;
    logic [LEN_W-1:0] beat_cnt;

    logic [31:0]      addr_a  [N];
    logic [LEN_W-1:0] len_a   [N];
    logic [2:0]       size_a  [N];
    logic [3:0]       wstrb_a [N];
    logic [31:0]      wdata_a [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_a[i]  = req_addr[i*32 +: 32];
            len_a[i]   = req_len[i*LEN_W +: LEN_W];
            size_a[i]  = req_size[i*3 +: 3];
            wstrb_a[i] = req_wstrb[i*4 +: 4];
            wdata_a[i] = req_wdata[i*32 +: 32];
        end
    end

    logic [N-1:0]     pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_picker #(.N(N), .IDX_W(IDX_W)) u_rr_picker (
        .req    (req_rd | req_wr),
        .ptr    (rr_ptr),
        .winner (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    logic [ID_W-1:0]  owner_id;
    logic             r_hit;
    logic             b_hit;
    logic [IDX_W-1:0] next_ptr;

    assign owner_id = ID_W'(owner);
    // Beats carrying another ID are accepted but never forwarded.
    assign r_hit    = rready && rvalid && (rid == owner_id);
    assign b_hit    = bready && bvalid && (bid == owner_id);
    assign next_ptr = (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            lat_addr <= '0;
            lat_len  <= '0;
            lat_size <= '0;
            beat_cnt <= '0;
            arvalid  <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            rready   <= 1'b0;
            bready   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_idx;
                        grant    <= pick_oh;
                        lat_addr <= addr_a[pick_idx];
                        lat_len  <= len_a[pick_idx];
                        lat_size <= size_a[pick_idx];
                        // A requester asking for both is served write-first.
                        if (req_wr[pick_idx]) begin
                            state   <= ST_AW;
                            awvalid <= 1'b1;
                        end else begin
                            state   <= ST_AR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hit && rlast) begin
                        rready <= 1'b0;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        wvalid   <= 1'b1;
                        beat_cnt <= '0;
                        state    <= ST_W;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (wlast) begin
                            wvalid <= 1'b0;
                            bready <= 1'b1;
                            state  <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (b_hit) begin
                        bready <= 1'b0;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign arid   = owner_id;
    assign araddr = lat_addr;
    assign arlen  = lat_len;
    assign arsize = lat_size;
    assign awid   = owner_id;
    assign awaddr = lat_addr;
    assign awlen  = lat_len;
    assign awsize = lat_size;

    // Write data comes live from the owner, which advances on rsp_wnext.
    assign wdata  = wdata_a[owner];
    assign wstrb  = wstrb_a[owner];
    assign wlast  = wvalid && (beat_cnt == lat_len);

    assign rsp_rdata  = rdata;
    assign rsp_rvalid = r_hit ? grant : '0;
    assign rsp_rlast  = r_hit && rlast;
    assign rsp_wnext  = (wvalid && wready) ? grant : '0;
    assign rsp_done   = ((r_hit && rlast) || b_hit) ? grant : '0;
    assign dbg_state  = state;

endmodule
